// File: rtl/dotp_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : dotp_ram_reader
// Description : Read-side sequencer for the dual-port vector RAM. On start it
//               walks len addresses of vector A (port a) and vector B (port b)
//               in lockstep, multiplies each returned pair and accumulates the
//               sum, then presents the dot product with a one-cycle done pulse.
//               Optional macro DOTP_SIGNED_EN selects two's-complement
//               operands and result; undefined means unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module dotp_ram_reader #(
  parameter  int WIDTH      = 8,
  parameter  int ADDR_WIDTH = 3,
  parameter  int DEPTH      = 8,
  localparam int ACC_WIDTH  = 2*WIDTH+ADDR_WIDTH+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic [ADDR_WIDTH-1:0] r_addr_a,
  output logic [ADDR_WIDTH-1:0] r_addr_b,
  input  logic [WIDTH-1:0]      rd_data_a,
  input  logic [WIDTH-1:0]      rd_data_b,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0]   C_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE  = ADDR_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                  valid_q, valid_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;

  logic [ADDR_WIDTH:0]   w_len_clamped;
  logic [2*WIDTH-1:0]    w_prod;
  logic [ACC_WIDTH-1:0]  w_prod_ext;

  assign w_len_clamped = (len > C_DEPTH) ? C_DEPTH : len;

`ifdef DOTP_SIGNED_EN
  // Sign-extend operands to full product width so the low 2*WIDTH bits are the signed product
  assign w_prod     = $signed({{WIDTH{rd_data_a[WIDTH-1]}}, rd_data_a}) *
                      $signed({{WIDTH{rd_data_b[WIDTH-1]}}, rd_data_b});
  assign w_prod_ext = {{(ACC_WIDTH-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
`else
  assign w_prod     = {{WIDTH{1'b0}}, rd_data_a} * {{WIDTH{1'b0}}, rd_data_b};
  assign w_prod_ext = {{(ACC_WIDTH-2*WIDTH){1'b0}}, w_prod};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an empty vector still passes through DRAIN so the
  // start-to-done latency is uniformly len+1 cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = (w_len_clamped == '0) ? C_DRAIN : C_ISSUE;
      C_ISSUE: if (cnt_q == len_q) state_d = C_DRAIN;
      C_DRAIN: state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      C_ISSUE: busy = 1'b1;
      C_DRAIN: busy = 1'b1;
      C_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: address walk, valid pipeline, accumulate, result capture
  always_comb begin
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    // Address presented during an ISSUE cycle returns data one cycle later
    valid_d  = (state_q == C_ISSUE);

    if (state_q == C_IDLE && start) begin
      len_d    = w_len_clamped;
      cnt_d    = C_CNT_ONE;
      addr_a_d = base_a;
      addr_b_d = base_b;
      acc_d    = '0;
    end else if (state_q == C_ISSUE && cnt_q != len_q) begin
      cnt_d    = cnt_q + C_CNT_ONE;
      addr_a_d = addr_a_q + C_ADDR_ONE;
      addr_b_d = addr_b_q + C_ADDR_ONE;
    end

    if (valid_q) acc_d = acc_q + w_prod_ext;

    // DRAIN's edge folds in the last pair and raises done together
    if (state_q == C_DRAIN) result_d = acc_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      cnt_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign r_addr_a = addr_a_q;
  assign r_addr_b = addr_b_q;
  assign result   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_dotp_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dotp_ram_reader
// Description : Self-checking bench for dotp_ram_reader with a registered-read
//               RAM model. Expected values follow DOTP_SIGNED_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dotp_ram_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic [2:0]  base_a;
  logic [2:0]  base_b;
  logic [2:0]  r_addr_a;
  logic [2:0]  r_addr_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        busy;
  logic        done;
  logic [19:0] result;

  dotp_ram_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .base_a    (base_a),
    .base_b    (base_b),
    .r_addr_a  (r_addr_a),
    .r_addr_b  (r_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM with one-cycle registered reads
  logic [7:0] mem [8];
  always @(posedge clk) begin
    rd_data_a <= mem[r_addr_a];
    rd_data_b <= mem[r_addr_b];
  end

  typedef struct {
    logic [63:0] img;
    logic [2:0]  ba;
    logic [2:0]  bb;
    logic [3:0]  ln;
    logic [19:0] exp_u;
    logic [19:0] exp_s;
    int          lat;
    int          hold;
    bit          chk_addr;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  int          got_lat;
  int          got_pulses;
  logic        got_busy0;
  logic [19:0] got_res_done;
  logic [2:0]  log_a [8];
  logic [2:0]  log_b [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [63:0] img);
    for (int i = 0; i < 8; i++) mem[i] = img[8*i +: 8];
  endtask

  // Issue one request; start optionally stays high with other operands
  // through the next 'hold' edges. Operands change after acceptance.
  task automatic run_op(input logic [2:0] ba, input logic [2:0] bb,
                        input logic [3:0] ln, input int hold);
    got_lat      = -1;
    got_pulses   = 0;
    got_res_done = 'x;
    @(negedge clk);
    start  = 1'b1;
    base_a = ba;
    base_b = bb;
    len    = ln;
    @(negedge clk);
    got_busy0 = busy;
    log_a[0]  = r_addr_a;
    log_b[0]  = r_addr_b;
    base_a    = ~ba;
    base_b    = ~bb;
    len       = 4'd3;
    start     = (hold > 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 8) begin
        log_a[i] = r_addr_a;
        log_b[i] = r_addr_b;
      end
      if (i == hold) start = 1'b0;
      if (done) begin
        got_pulses++;
        if (got_lat < 0) begin
          got_lat      = i;
          got_res_done = result;
        end
      end
    end
  endtask

  initial begin
    // img byte i is the RAM word at address i
    vecs[0] = '{64'h0807060504030201, 3'd0, 3'd4, 4'd4,  20'd70,     20'd70,     5, 0, 1'b0};
    vecs[1] = '{64'h0602090501040103, 3'd6, 3'd2, 4'd4,  20'd38,     20'd38,     5, 0, 1'b1};
    vecs[2] = '{64'h0807060504030201, 3'd1, 3'd2, 4'd0,  20'd0,      20'd0,      1, 0, 1'b0};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd0, 4'd8,  20'd520200, 20'd8,      9, 0, 1'b0};
    vecs[4] = '{64'h00000000FC0302FF, 3'd0, 3'd2, 4'd2,  20'd1269,   20'hFFFF5,  3, 0, 1'b0};
    vecs[5] = '{64'h0807060504030201, 3'd0, 3'd0, 4'd12, 20'd204,    20'd204,    9, 0, 1'b0};
    vecs[6] = '{64'h0807060504030201, 3'd3, 3'd5, 4'd1,  20'd24,     20'd24,     2, 0, 1'b0};
    vecs[7] = '{64'h0807060504030201, 3'd0, 3'd4, 4'd4,  20'd70,     20'd70,     5, 3, 1'b0};
    vecs[8] = '{64'h0807060504030201, 3'd7, 3'd0, 4'd15, 20'd176,    20'd176,    9, 0, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    len    = '0;
    base_a = '0;
    base_b = '0;
    load_mem(64'h0);
    repeat (3) @(negedge clk);
    chk("reset_addr_a", 32'(r_addr_a), 32'd0);
    chk("reset_addr_b", 32'(r_addr_b), 32'd0);
    chk("reset_busy",   32'(busy),     32'd0);
    chk("reset_done",   32'(done),     32'd0);
    chk("reset_result", 32'(result),   32'd0);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      logic [19:0] exp;
`ifdef DOTP_SIGNED_EN
      exp = vecs[v].exp_s;
`else
      exp = vecs[v].exp_u;
`endif
      load_mem(vecs[v].img);
      run_op(vecs[v].ba, vecs[v].bb, vecs[v].ln, vecs[v].hold);
      chk($sformatf("v%0d_busy_after_E0", v), 32'(got_busy0),    32'd1);
      chk($sformatf("v%0d_latency", v),       32'(got_lat),      32'(vecs[v].lat));
      chk($sformatf("v%0d_done_pulses", v),   32'(got_pulses),   32'd1);
      chk($sformatf("v%0d_result", v),        32'(got_res_done), 32'(exp));
      chk($sformatf("v%0d_result_held", v),   32'(result),       32'(exp));
      chk($sformatf("v%0d_busy_idle", v),     32'(busy),         32'd0);
      if (vecs[v].chk_addr) begin
        for (int j = 0; j < 4; j++) begin
          logic [2:0] ea;
          logic [2:0] eb;
          ea = vecs[v].ba + 3'(j);
          eb = vecs[v].bb + 3'(j);
          chk($sformatf("v%0d_addr_a_%0d", v, j), 32'(log_a[j]), 32'(ea));
          chk($sformatf("v%0d_addr_b_%0d", v, j), 32'(log_b[j]), 32'(eb));
        end
      end
    end

    // Reset asserted shortly after E2 of an 8-element run
    load_mem(64'h0807060504030201);
    @(negedge clk);
    start  = 1'b1;
    base_a = 3'd0;
    base_b = 3'd0;
    len    = 4'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy",   32'(busy),     32'd0);
    chk("midrst_done",   32'(done),     32'd0);
    chk("midrst_addr_a", 32'(r_addr_a), 32'd0);
    chk("midrst_addr_b", 32'(r_addr_b), 32'd0);
    chk("midrst_result", 32'(result),   32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);
    end
    run_op(3'd0, 3'd4, 4'd4, 0);
    chk("postrst_latency", 32'(got_lat),      32'd5);
    chk("postrst_result",  32'(got_res_done), 32'd70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
